// File: rtl/window_5x5_gen_if.sv
// Pixel stream in / 5x5 window out bundle for window_5x5_gen.
// master = pixel source side, slave = window generator side.
interface window_5x5_gen_if #(
  parameter int CW = 10,
  parameter int RW = 9
);
  logic          sof;
  logic          pix_valid;
  logic [7:0]    pix_in;
  logic          win_valid;
  logic [199:0]  win_out;
  logic [CW-1:0] win_x;
  logic [RW-1:0] win_y;
  logic          frame_done;

  modport master (
    output sof, pix_valid, pix_in,
    input  win_valid, win_out, win_x, win_y, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output win_valid, win_out, win_x, win_y, frame_done
  );
endinterface

// File: rtl/window_5x5_gen.sv
// Sliding 5x5 luma neighbourhood generator: 4 line buffers feed a 5x5 register
// array; one packed window per interior pixel, one cycle after acceptance.
module window_5x5_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic             clk,
  input logic             rst_n,
  window_5x5_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // state | meaning
  // IDLE  | waiting for a sof pixel; non-sof pixels dropped
  // RUN   | accepting pixels, counters track the next position
  // DONE  | last pixel taken, frame_done high this cycle
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_lb  [4][IMG_W];
  logic [7:0]    r_win [5][5];
  logic          r_win_valid;
  logic [CW-1:0] r_win_x;
  logic [RW-1:0] r_win_y;
  logic          r_frame_done;

  logic          w_accept;
  logic [CW-1:0] w_c;
  logic [RW-1:0] w_r;
  logic          w_last;
  logic          w_interior;
  logic [199:0]  w_win_out;

  // A sof pixel always lands at (0,0), whatever the current state.
  assign w_accept   = bus.pix_valid && (bus.sof || (r_state == RUN));
  assign w_c        = bus.sof ? '0 : r_col;
  assign w_r        = bus.sof ? '0 : r_row;
  assign w_last     = (w_r == RW'(IMG_H - 1)) && (w_c == CW'(IMG_W - 1));
  assign w_interior = (w_r >= RW'(4)) && (w_c >= CW'(4));

  // Line buffers hold no reset; stale contents never reach a valid window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[3][w_c] <= bus.pix_in;
      for (int k = 0; k < 3; k++) r_lb[k][w_c] <= r_lb[k+1][w_c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_frame_done <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) r_win[r][c] <= '0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 4; c++) r_win[r][c] <= r_win[r][c+1];
        for (int r = 0; r < 4; r++) r_win[r][4] <= r_lb[r][w_c];
        r_win[4][4] <= bus.pix_in;
        if (w_interior) begin
          r_win_valid <= 1'b1;
          r_win_x     <= w_c - CW'(2);
          r_win_y     <= w_r - RW'(2);
        end
        if (w_last) begin
          r_state      <= DONE;
          r_frame_done <= 1'b1;
          r_col        <= '0;
          r_row        <= '0;
        end else begin
          r_state <= RUN;
          if (w_c == CW'(IMG_W - 1)) begin
            r_col <= '0;
            r_row <= w_r + RW'(1);
          end else begin
            r_col <= w_c + CW'(1);
            r_row <= w_r;
          end
        end
      end else if (r_state == DONE) begin
        r_state <= IDLE;
      end
    end
  end

  always_comb begin
    w_win_out = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) w_win_out[8*(5*r+c) +: 8] = r_win[r][c];
  end

  assign bus.win_valid  = r_win_valid;
  assign bus.win_out    = w_win_out;
  assign bus.win_x      = r_win_x;
  assign bus.win_y      = r_win_y;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_window_5x5_gen.sv
// Randomised bench for window_5x5_gen on an 8x6 frame, checked every cycle
// against a frame-array model of accepted pixels.
module tb_window_5x5_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_5x5_gen_if #(.CW(CW), .RW(RW)) bus();
  window_5x5_gen #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // model: image of the current frame plus a running accepted-pixel count
  logic [7:0]   img [H][W];
  bit           in_frame;
  int           n;
  bit           exp_valid, exp_done, hold_ok;
  logic [199:0] exp_win;
  int           exp_x, exp_y;

  int           win_cnt, done_cnt;
  logic [199:0] first_win, last_win;
  logic [CW-1:0] first_x, last_x;
  logic [RW-1:0] first_y, last_y;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_frame  = 1'b0;
    n         = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    hold_ok   = 1'b1;
    exp_win   = '0;
    exp_x     = 0;
    exp_y     = 0;
  endtask

  task automatic check_outputs();
    chk("win_valid", 200'(bus.win_valid), 200'(exp_valid));
    chk("frame_done", 200'(bus.frame_done), 200'(exp_done));
    if (exp_valid || hold_ok) begin
      chk("win_out", bus.win_out, exp_win);
      chk("win_x", 200'(bus.win_x), 200'(exp_x[CW-1:0]));
      chk("win_y", 200'(bus.win_y), 200'(exp_y[RW-1:0]));
    end
    if (bus.win_valid) begin
      if (win_cnt == 0) begin
        first_win = bus.win_out; first_x = bus.win_x; first_y = bus.win_y;
      end
      last_win = bus.win_out; last_x = bus.win_x; last_y = bus.win_y;
      win_cnt++;
    end
    if (bus.frame_done) done_cnt++;
  endtask

  task automatic step(input bit v, input bit s, input logic [7:0] p);
    int r, c;
    bus.pix_valid = v;
    bus.sof       = s;
    bus.pix_in    = p;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (v && (s || in_frame)) begin
      if (s) begin
        n = 0;
        in_frame = 1'b1;
      end
      r = n / W;
      c = n % W;
      img[r][c] = p;
      hold_ok = 1'b0;
      if (r >= 4 && c >= 4) begin
        exp_valid = 1'b1;
        hold_ok   = 1'b1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) exp_win[8*(5*i+j) +: 8] = img[r-4+i][c-4+j];
        exp_x = c - 2;
        exp_y = r - 2;
      end
      n++;
      if (n == W * H) begin
        in_frame = 1'b0;
        exp_done = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic send_frame(input int base, input bit rnd, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        gap(gaps);
        step(1'b1, (r == 0 && c == 0), rnd ? 8'($urandom) : 8'(base + 16*r + c));
      end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_counts();
    win_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic check_ref_frame(input string tag);
    chk({tag, " windows"}, 200'(win_cnt), 200'd8);
    chk({tag, " frame_done pulses"}, 200'(done_cnt), 200'd1);
    chk({tag, " first[7:0]"}, 200'(first_win[7:0]), 200'h00);
    chk({tag, " first[103:96]"}, 200'(first_win[103:96]), 200'h22);
    chk({tag, " first[199:192]"}, 200'(first_win[199:192]), 200'h44);
    chk({tag, " first x"}, 200'(first_x), 200'd2);
    chk({tag, " first y"}, 200'(first_y), 200'd2);
    chk({tag, " last x"}, 200'(last_x), 200'd5);
    chk({tag, " last y"}, 200'(last_y), 200'd3);
    chk({tag, " last[199:192]"}, 200'(last_win[199:192]), 200'h57);
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.pix_in    = 8'h00;
    model_reset();
    clear_counts();
    first_win = '0; last_win = '0;
    first_x = '0; last_x = '0; first_y = '0; last_y = '0;

    repeat (2) @(negedge clk);
    chk("reset win_valid", 200'(bus.win_valid), 200'd0);
    chk("reset win_out", bus.win_out, 200'd0);
    chk("reset frame_done", 200'(bus.frame_done), 200'd0);
    rst_n = 1'b1;
    idle(2);

    // contiguous reference frame
    clear_counts();
    send_frame(0, 1'b0, 1'b0);
    idle(3);
    check_ref_frame("t1");

    // same frame with random gaps and stray sof without pix_valid
    clear_counts();
    send_frame(0, 1'b0, 1'b1);
    idle(3);
    check_ref_frame("t2");

    // leading non-sof pixels while idle are dropped
    clear_counts();
    repeat (5) step(1'b1, 1'b0, 8'($urandom));
    send_frame(0, 1'b0, 1'b0);
    idle(2);
    check_ref_frame("t3");

    // mid-frame restart at (3,5)
    clear_counts();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || (r == 3 && c < 5)) step(1'b1, (r == 0 && c == 0), 8'(16*r + c));
    send_frame(8'h80, 1'b0, 1'b1);
    idle(2);
    chk("t4 windows", 200'(win_cnt), 200'd8);
    chk("t4 frame_done pulses", 200'(done_cnt), 200'd1);
    chk("t4 first[199:192]", 200'(first_win[199:192]), 200'hC4);

    // async reset mid-frame at (4,5)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 4 || (r == 4 && c <= 5)) step(1'b1, (r == 0 && c == 0), 8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset win_valid", 200'(bus.win_valid), 200'd0);
    chk("mid reset win_out", bus.win_out, 200'd0);
    chk("mid reset win_x", 200'(bus.win_x), 200'd0);
    chk("mid reset win_y", 200'(bus.win_y), 200'd0);
    chk("mid reset frame_done", 200'(bus.frame_done), 200'd0);
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_counts();
    step(1'b1, 1'b0, 8'hAA);
    send_frame(0, 1'b0, 1'b0);
    idle(2);
    check_ref_frame("t5");

    // back-to-back frames, second sof right after the last pixel
    clear_counts();
    send_frame(0, 1'b0, 1'b0);
    send_frame(0, 1'b1, 1'b0);
    idle(3);
    chk("t6 windows", 200'(win_cnt), 200'd16);
    chk("t6 frame_done pulses", 200'(done_cnt), 200'd2);

    // random-data frames with gaps
    clear_counts();
    repeat (3) send_frame(0, 1'b1, 1'b1);
    idle(2);
    chk("t7 windows", 200'(win_cnt), 200'd24);
    chk("t7 frame_done pulses", 200'(done_cnt), 200'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
